muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit. It replaces the separate fixed-width mult and div blocks with one engine that supports signed and unsigned modes for both operations. It sits beside the ALU in the multicycle datapath: operands come from the A/B registers, and results go to the HI/LO registers. The control unit talks to it through a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits; iteration count equals WIDTH.
ABORT_EN, 1, when 1 the abort input is honoured; when 0 abort is ignored.

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
abort  input  1  cancels an in-flight operation
src_a  input  WIDTH  multiplicand / dividend; sampled with start
src_b  input  WIDTH  multiplier / divisor; sampled with start
hi  output  WIDTH  MULT: upper product half; DIV: remainder
lo  output  WIDTH  MULT: lower product half; DIV: quotient
busy  output  1  high from accepting edge until done edge
done  output  1  one-cycle completion pulse
div_zero  output  1  high with done when a DIV/DIVU divisor was 0

Behaviour:
- Reset, asynchronous and active-high: state IDLE; hi, lo, busy, done, div_zero all 0; internal counter and accumulators 0.
- States: IDLE, RUN, FIN, ZERO.
- IDLE with start=1 (accepting edge, t0):
  - op, src_a and src_b are latched.
  - For signed ops, operand magnitudes are taken and result signs recorded: product sign = a^b; quotient sign = a^b; remainder sign = sign of a.
  - If op is DIV/DIVU and src_b=0: go to ZERO.
  - Otherwise: go to RUN with counter=0, and busy=1.
- RUN: one iteration per edge, WIDTH iterations total (edges t1..tWIDTH), then go to FIN.
  - MULT: shift-add on the 2*WIDTH-bit accumulator.
  - DIV: restoring divide, one quotient bit per edge.
- FIN (edge tWIDTH+1):
  - Apply sign correction by two's complement.
  - Load hi/lo.
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: done is high in the cycle following edge t(WIDTH+1); for WIDTH=32, 33 edges after acceptance.
- ZERO (edge t1): done=1 and div_zero=1 for one cycle, busy=0, return to IDLE. hi and lo keep their previous values.
- div_zero is 0 on every done except the ZERO case. It clears on the next edge.
- hi and lo change only at FIN. They hold their values between operations.
- While busy=1, start is ignored; operands are not resampled and no queueing occurs.
- start in the same cycle done is high: accepted, since the state is IDLE on that edge. Back-to-back operations are allowed.
- abort (ABORT_EN=1) while in RUN or ZERO: next edge goes to IDLE with busy=0. No done pulse, hi/lo unchanged.
  - abort in IDLE has no effect.
  - abort together with start in IDLE: start wins.
- Reset during RUN: immediate return to the reset state. No done, hi/lo cleared to 0.
- Signed arithmetic rules:
  - Signed results truncate to 2*WIDTH bits; no overflow flag.
  - Remainder takes the dividend's sign; the quotient truncates toward zero.
  - DIV of most-negative by -1: lo = most-negative (0x80000000 at WIDTH=32), hi=0, no flag.
  - MULT of most-negative by most-negative: hi=0x40000000, lo=0 at WIDTH=32.
- The output products and quotients are purely a function of the latched operands. Changes on src_a/src_b after acceptance have no effect.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 -> done at t33: hi=0xFFFFFFFF, lo=0xFFFFFFFE, div_zero=0; the same operands with MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIV with b=0 after a prior result hi=0x12345678 -> done and div_zero both high one cycle after acceptance, busy high for 1 cycle; hi still 0x12345678.
- Corners at WIDTH=32:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- start pulsed at t5 of a running op with new operands -> ignored, first result unaffected. start asserted in the done cycle -> second op accepted, done after a further 33 edges.
- abort at t10 -> busy=0 at t11, no done, hi/lo unchanged. reset asserted at t10 of a new op -> hi, lo, busy and done are 0 asynchronously. Repeat a subset with WIDTH=8 (MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01, done after 9 edges).

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the control unit and muldiv_unit.
//   master : control unit side (drives start/op/abort/operands, sees results)
//   slave  : muldiv_unit side
// Signals:
//   start, op[1:0], abort, src_a, src_b  -> request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi, lo, busy, done, div_zero         <- result and status
interface muldiv_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic             abort;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, abort, src_a, src_b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, abort, src_a, src_b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine for the multicycle datapath.
// One iteration per clock, WIDTH iterations, then a sign-fix/writeback cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : muldiv_unit_if.slave (start/op/abort/src_a/src_b in; hi/lo/busy/done/div_zero out)
// Parameters:
//   WIDTH    : operand width (>= 2); hi/lo are WIDTH bits each
//   ABORT_EN : 1 honours abort in RUN/ZERO, 0 ignores it
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit ABORT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN, ZERO} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 div_q, div_d;     // 1: divide, 0: multiply
  logic                 sgn_q, sgn_d;     // product / quotient negative
  logic                 rsgn_q, rsgn_d;   // remainder negative
  logic [WIDTH-1:0]     mb_q, mb_d;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // {partial/remainder, multiplier/quotient}
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  // Operand magnitudes at acceptance; unsigned ops never see a sign.
  logic             is_signed, a_neg, b_neg, abort_ok;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.src_a[WIDTH-1];
  assign b_neg     = is_signed & bus.src_b[WIDTH-1];
  assign mag_a     = a_neg ? -bus.src_a : bus.src_a;
  assign mag_b     = b_neg ? -bus.src_b : bus.src_b;
  assign abort_ok  = ABORT_EN && bus.abort;

  // Shift-add step: add multiplicand to the upper half when the multiplier
  // LSB is set; the carry becomes the new MSB after the right shift.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? mb_q : {WIDTH{1'b0}})};

  // Restoring-divide step: shift the next dividend bit into the remainder and
  // trial-subtract. Bit WIDTH of the difference is the borrow (restore case).
  logic [WIDTH:0] div_sh, div_diff;
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mb_q};

  // Sign correction applied at writeback.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = sgn_q  ? -acc_q : acc_q;
  assign quo_fix  = sgn_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rsgn_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    rsgn_d  = rsgn_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          div_d  = bus.op[1];
          sgn_d  = a_neg ^ b_neg;
          rsgn_d = a_neg;
          busy_d = 1'b1;
          cnt_d  = '0;
          if (bus.op[1]) begin
            mb_d  = mag_b;
            acc_d = {{WIDTH{1'b0}}, mag_a};
          end else begin
            mb_d  = mag_a;
            acc_d = {{WIDTH{1'b0}}, mag_b};
          end
          state_d = (bus.op[1] && bus.src_b == '0) ? ZERO : RUN;
        end
      end
      RUN: begin
        if (abort_ok) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (div_q) begin
            if (div_diff[WIDTH])
              acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else
              acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1))
            state_d = FIN;
        end
      end
      FIN: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ZERO: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!abort_ok) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      mb_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      rsgn_q  <= rsgn_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule
